fetch_decode_stage: RTL and testbench

- Fetch/pre-decode stage directly upstream of the immediate-extend unit.
- Issues in-order instruction-memory reads and buffers returned words in a 2-entry FIFO.
- Presents instr/pc/imm_src to decode through a valid/ready handshake; instr[31:7] and imm_src drive the extend unit directly.
- Supports redirect (branch/jump) with flush and drop of in-flight responses.

---
 rtl/fetch_decode_stage_if.sv | 35 +++
 rtl/fetch_decode_stage.sv | 145 ++++++++++++++
 tb/tb_fetch_decode_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_stage_if.sv
`default_nettype none
// ============================================================================
// fetch_decode_stage_if : bus bundle for the fetch stage (imem, decode, redirect)
// Rev 1.0 : initial release
// ============================================================================
interface fetch_decode_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [1:0]  id_imm_src;
    logic        id_illegal;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_addr,
        output id_valid, id_instr, id_pc, id_imm_src, id_illegal,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  id_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        input  id_valid, id_instr, id_pc, id_imm_src, id_illegal,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output id_ready, redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_decode_stage.sv
`default_nettype none
// ============================================================================
// fetch_decode_stage : in-order imem fetch, 2-entry return FIFO, opcode pre-decode
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
// Rev 1.0 : initial release
// ============================================================================
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    fetch_decode_stage_if.master  bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_flushed
`endif
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] ret_pc_q,   ret_pc_d;
    logic [1:0]  out_q,      out_d;
    logic [1:0]  drop_q,     drop_d;
    logic [1:0]  count_q,    count_d;
    logic        wr_ptr_q,   wr_ptr_d;
    logic        rd_ptr_q,   rd_ptr_d;
    logic [31:0] instr_q [2];
    logic [31:0] pc_q    [2];

    logic        w_budget;
    logic        w_req_valid;
    logic        w_fire;
    logic        w_rsp_ok;
    logic        w_push;
    logic        w_pop;
    logic        w_redir;
    logic [31:0] w_redir_pc;

    assign w_redir     = bus.redirect_valid;
    assign w_redir_pc  = {bus.redirect_pc[31:2], 2'b00};
    // In-flight requests and buffered words share the FIFO's capacity.
    assign w_budget    = ({1'b0, out_q} + {1'b0, count_q}) < 3'(MAX_OUTSTANDING);
    assign w_req_valid = rst_n && w_budget && !w_redir;
    assign w_fire      = w_req_valid && bus.imem_req_ready;
    assign w_rsp_ok    = bus.imem_rsp_valid && (out_q != 2'd0);
    assign w_push      = w_rsp_ok && (drop_q == 2'd0) && !w_redir;
    assign w_pop       = (count_q != 2'd0) && bus.id_ready && !w_redir;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        ret_pc_d   = ret_pc_q;
        out_d      = out_q + {1'b0, w_fire} - {1'b0, w_rsp_ok};
        drop_d     = drop_q;
        count_d    = count_q + {1'b0, w_push} - {1'b0, w_pop};
        wr_ptr_d   = wr_ptr_q ^ w_push;
        rd_ptr_d   = rd_ptr_q ^ w_pop;
        if (w_redir) begin
            fetch_pc_d = w_redir_pc;
            ret_pc_d   = w_redir_pc;
            drop_d     = out_q - {1'b0, w_rsp_ok};
            count_d    = 2'd0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
        end else begin
            if (w_fire)
                fetch_pc_d = fetch_pc_q + 32'd4;
            if (w_push)
                ret_pc_d = ret_pc_q + 32'd4;
            if (w_rsp_ok && (drop_q != 2'd0))
                drop_d = drop_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            ret_pc_q   <= RESET_PC;
            out_q      <= 2'd0;
            drop_q     <= 2'd0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= 32'd0;
                pc_q[i]    <= 32'd0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            ret_pc_q   <= ret_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (w_push) begin
                instr_q[wr_ptr_q] <= bus.imem_rsp_data;
                pc_q[wr_ptr_q]    <= ret_pc_q;
            end
        end
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_addr      = fetch_pc_q;
    assign bus.id_valid       = (count_q != 2'd0);
    assign bus.id_instr       = instr_q[rd_ptr_q];
    assign bus.id_pc          = pc_q[rd_ptr_q];

    // Illegal is qualified by valid so an empty FIFO never flags a zero opcode.
    always_comb begin
        bus.id_imm_src = 2'b00;
        bus.id_illegal = 1'b0;
        case (instr_q[rd_ptr_q][6:0])
            7'b0000011, 7'b0010011, 7'b1100111,
            7'b0110011, 7'b0110111, 7'b0010111: bus.id_imm_src = 2'b00;
            7'b0100011:                         bus.id_imm_src = 2'b01;
            7'b1100011:                         bus.id_imm_src = 2'b10;
            7'b1101111:                         bus.id_imm_src = 2'b11;
            default:                            bus.id_illegal = (count_q != 2'd0);
        endcase
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= 32'd0;
            perf_flushed_q <= 32'd0;
        end else begin
            perf_fetched_q <= perf_fetched_q + {31'd0, w_pop};
            if (w_redir)
                perf_flushed_q <= perf_flushed_q + {30'd0, count_q} + {31'd0, w_rsp_ok};
            else
                perf_flushed_q <= perf_flushed_q + {31'd0, w_rsp_ok && (drop_q != 2'd0)};
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_stage.sv
`default_nettype none
// ============================================================================
// tb_fetch_decode_stage : directed + random bench with an address-stream reference model
// Rev 1.0 : initial release
// ============================================================================
module tb_fetch_decode_stage;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } req_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    req_t        pend[$];
    logic [31:0] fq[$];
    logic [31:0] exp_fetch;
    bit          stale_rsp;

    fetch_decode_stage_if bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    fetch_decode_stage #(
        .RESET_PC        (C_RESET_PC),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: opcode set by addr[4:2], upper bits tagged by address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] t;
        case (a[4:2])
            3'd0:    t = 32'h00A0_0093;
            3'd1:    t = 32'h0011_2023;
            3'd2:    t = 32'hFE00_0EE3;
            3'd3:    t = 32'h0080_00EF;
            3'd4:    t = 32'h0000_007F;
            3'd5:    t = 32'h0000_0033;
            3'd6:    t = 32'h0000_00B7;
            default: t = 32'h0000_0017;
        endcase
        return t ^ {a[26:2], 7'b0};
    endfunction

    // Returns {imm_src, illegal} for an opcode.
    function automatic logic [2:0] dec_ref(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111,
            7'b0110011, 7'b0110111, 7'b0010111: return 3'b00_0;
            7'b0100011:                         return 3'b01_0;
            7'b1100011:                         return 3'b10_0;
            7'b1101111:                         return 3'b11_0;
            default:                            return 3'b00_1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input bit leave_stale);
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        rst_n = 1'b0;
        #1;
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_id_valid",  bus.id_valid,       0);
        chk("rst_id_instr",  bus.id_instr,       0);
        chk("rst_id_pc",     bus.id_pc,          0);
        chk("rst_imm_src",   bus.id_imm_src,     0);
        chk("rst_illegal",   bus.id_illegal,     0);
        pend.delete();
        fq.delete();
        exp_fetch = C_RESET_PC;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        stale_rsp = leave_stale;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit rdy, input bit rsp_en, input bit idr,
                        input bit redir, input logic [31:0] rpc);
        bit          do_rsp;
        bit          do_pop;
        req_t        r;
        logic [2:0]  d;
        int          occ;
        do_rsp = rsp_en && (pend.size() > 0);
        bus.imem_req_ready = rdy;
        bus.id_ready       = idr;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.imem_rsp_valid = do_rsp || stale_rsp;
        bus.imem_rsp_data  = do_rsp ? mem_word(pend[0].addr) : 32'h0000_0013;
        #1;
        occ = pend.size() + fq.size();
        chk("req_valid", bus.imem_req_valid, 64'(!redir && (occ < 2)));
        if (bus.imem_req_valid)
            chk("imem_addr", bus.imem_addr, exp_fetch);
        chk("id_valid", bus.id_valid, 64'(fq.size() > 0));
        if (fq.size() > 0) begin
            d = dec_ref(mem_word(fq[0])[6:0]);
            chk("id_pc",      bus.id_pc,      fq[0]);
            chk("id_instr",   bus.id_instr,   mem_word(fq[0]));
            chk("id_imm_src", bus.id_imm_src, d[2:1]);
            chk("id_illegal", bus.id_illegal, d[0]);
        end
        do_pop = !redir && idr && (fq.size() > 0);
        if (do_rsp) begin
            r = pend.pop_front();
            if (!r.stale && !redir)
                fq.push_back(r.addr);
        end
        if (do_pop)
            void'(fq.pop_front());
        if (redir) begin
            fq.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            exp_fetch = {rpc[31:2], 2'b00};
        end else if (bus.imem_req_valid && rdy) begin
            pend.push_back('{addr: exp_fetch, stale: 1'b0});
            exp_fetch = exp_fetch + 32'd4;
        end
        stale_rsp = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        stale_rsp = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);

        // Streaming fetch from reset, 1-cycle memory, decode always ready.
        do_reset(1'b0);
        repeat (12) step(1, 1, 1, 0, 32'd0);

        // Restart at 0 and stall decode: FIFO fills with 0 and 4, requests stop.
        step(1, 1, 1, 1, 32'd0);
        repeat (6) step(1, 1, 0, 0, 32'd0);
        repeat (6) step(1, 1, 1, 0, 32'd0);

        // Two outstanding at 8/12, then redirect to 0x103 (aligned to 0x100).
        step(1, 1, 1, 1, 32'd8);
        repeat (2) step(1, 0, 1, 0, 32'd0);
        step(1, 0, 1, 1, 32'h0000_0103);
        repeat (8) step(1, 1, 1, 0, 32'd0);

        // Memory stalls 3 cycles, then redirect withdraws the pending request.
        repeat (3) step(0, 1, 1, 0, 32'd0);
        step(0, 1, 1, 1, 32'h0000_0200);
        repeat (6) step(1, 1, 1, 0, 32'd0);

        // Random traffic, including wrap of the fetch address.
        repeat (300) step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                          $urandom);
        step(1, 1, 1, 1, 32'hFFFF_FFF0);
        repeat (300) step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
                          {$urandom_range(0, 1) == 1 ? 24'hFFFFFF : 24'h000000, 8'($urandom)});

        // Reset with FIFO full; a stray response right after release must be ignored.
        repeat (5) step(1, 1, 0, 0, 32'd0);
        do_reset(1'b1);
        repeat (8) step(1, 1, 1, 0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
